queue_push_arbiter: RTL and testbench

Round-robin push arbiter that shares one circular FIFO `queue` instance among NUM_REQ producers, e.g. several functional units writing into one completion or free-list queue. It grants at most one requester per cycle, registers the winner's data, and presents it to the queue's push port as a one-entry valid/stall stage. The stage holds its data while the queue reports full. An optional lock lets one producer push a multi-entry burst without interleaving. The block sits between the producers and the queue's `pushReq_IN`/`data_IN`/`fullFlag_OUT`/`flush_IN` pins.

---
 rtl/queue_arb_pkg.sv | 23 ++
 rtl/rr_priority_pick.sv | 45 ++++
 rtl/queue_push_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_queue_push_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/queue_arb_pkg.sv
// Shared definitions for the queue push arbiter.
//
// Contents:
//   - arb_state_t  : one-bit FSM state type.
//   - StArb        : free round-robin arbitration (reset state).
//   - StLocked     : one producer owns the push port for a burst.
//   - STALL_CNT_WIDTH : width of the saturating stall counter.
//   - stall_cnt_max   : helper returning the counter's saturation value.

package queue_arb_pkg;

    typedef logic arb_state_t;

    localparam arb_state_t StArb    = 1'b0;
    localparam arb_state_t StLocked = 1'b1;

    localparam int unsigned STALL_CNT_WIDTH = 16;

    function automatic logic [STALL_CNT_WIDTH-1:0] stall_cnt_max();
        return {STALL_CNT_WIDTH{1'b1}};
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-priority picker.
//
// Scans the request vector upward starting at start_i, wrapping cyclically, and
// returns the first requester found. Purely combinational.
//
// Ports:
//   req_i    in   NUM_REQ    request vector
//   start_i  in   SRC_WIDTH  index with highest priority this cycle
//   grant_o  out  NUM_REQ    one-hot winner, zero when no request
//   idx_o    out  SRC_WIDTH  index of the winner, zero when no request
//   valid_o  out  1          at least one request present

module rr_priority_pick #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned SRC_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [SRC_WIDTH-1:0] start_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic [SRC_WIDTH-1:0] idx_o,
    output logic                 valid_o
);

    logic [SRC_WIDTH-1:0] cand;
    logic                 found;

    // NUM_REQ is a power of two, so SRC_WIDTH-bit addition wraps exactly at
    // NUM_REQ and no explicit modulo is needed.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = start_i + SRC_WIDTH'(k);
            if (!found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/queue_push_arbiter.sv
// Round-robin push arbiter in front of a shared circular FIFO.
//
// Grants at most one producer per cycle, registers the winner's data in a
// one-entry valid/stall stage and drives the queue push port from it. A
// producer that asserts its lock bit when granted keeps the port for a burst.
//
// Ports:
//   clk           in   1                   clock, rising edge
//   reset         in   1                   synchronous, active-high
//   req_IN        in   NUM_REQ             per-producer push request (level)
//   lock_IN       in   NUM_REQ             per-producer burst lock, sampled at grant
//   reqData_IN    in   NUM_REQ*DATA_WIDTH  producer i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant_OUT     out  NUM_REQ             one-hot or zero, transfer at this edge
//   qFull_IN      in   1                   queue full flag
//   flush_IN      in   1                   pipeline flush, also flushes the queue
//   pushReq_OUT   out  1                   registered push request to the queue
//   pushData_OUT  out  DATA_WIDTH          registered push data to the queue
//   pushSrc_OUT   out  SRC_WIDTH           producer index of the staged entry
//   locked_OUT    out  1                   FSM is in the locked state
//   stallCnt_OUT  out  16                  saturating count of stalled push cycles

module queue_push_arbiter
    import queue_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned SRC_WIDTH  = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_IN,
    input  logic [NUM_REQ-1:0]            lock_IN,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData_IN,
    output logic [NUM_REQ-1:0]            grant_OUT,
    input  logic                          qFull_IN,
    input  logic                          flush_IN,
    output logic                          pushReq_OUT,
    output logic [DATA_WIDTH-1:0]         pushData_OUT,
    output logic [SRC_WIDTH-1:0]          pushSrc_OUT,
    output logic                          locked_OUT,
    output logic [STALL_CNT_WIDTH-1:0]    stallCnt_OUT
);

    // State
    arb_state_t                 state_q, state_d;
    logic [SRC_WIDTH-1:0]       owner_q, owner_d;
    logic [SRC_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
    logic                       out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]      out_data_q, out_data_d;
    logic [SRC_WIDTH-1:0]       out_src_q, out_src_d;
    logic [STALL_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Combinational helpers
    logic                  accept;
    logic                  can_load;
    logic                  grant_en;
    logic                  hold_lock;
    logic                  stalled;
    logic [NUM_REQ-1:0]    owner_oh;
    logic [NUM_REQ-1:0]    pick_grant;
    logic [SRC_WIDTH-1:0]  pick_idx;
    logic                  pick_valid;
    logic                  gnt_any;
    logic [SRC_WIDTH-1:0]  gnt_idx;
    logic [DATA_WIDTH-1:0] gnt_data;

    rr_priority_pick #(
        .NUM_REQ   (NUM_REQ),
        .SRC_WIDTH (SRC_WIDTH)
    ) u_pick (
        .req_i   (req_IN),
        .start_i (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        accept   = out_valid_q & ~qFull_IN;
        can_load = ~out_valid_q | accept;
        grant_en = ~reset & ~flush_IN & can_load;
        stalled  = out_valid_q & qFull_IN;
        owner_oh = NUM_REQ'(1) << owner_q;
        // The lock survives only while the owner keeps both request and lock
        // high; otherwise this cycle is already arbitrated with ARB rules.
        hold_lock = (state_q == StLocked) & req_IN[owner_q] & lock_IN[owner_q];
    end

    // Grant selection. No path from reqData_IN.
    always_comb begin
        grant_OUT = '0;
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        if (hold_lock) begin
            if (grant_en) begin
                grant_OUT = owner_oh;
                gnt_any   = 1'b1;
                gnt_idx   = owner_q;
            end
        end else if (grant_en && pick_valid) begin
            grant_OUT = pick_grant;
            gnt_any   = 1'b1;
            gnt_idx   = pick_idx;
        end
    end

    // AND-OR mux of the granted producer's data; grant_OUT is one-hot or zero.
    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_OUT[i]) begin
                gnt_data = gnt_data | reqData_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        if (flush_IN) begin
            state_d = StArb;
        end else if (hold_lock) begin
            state_d = StLocked;
        end else begin
            state_d = StArb;
            if (gnt_any) begin
                rr_ptr_d = gnt_idx + SRC_WIDTH'(1);
                if (lock_IN[gnt_idx]) begin
                    state_d = StLocked;
                    owner_d = gnt_idx;
                end
            end
        end
    end

    // Output stage: a new grant and an accept may coincide (back-to-back push).
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (flush_IN) begin
            out_valid_d = 1'b0;
        end else if (gnt_any) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_src_d   = gnt_idx;
        end else if (accept) begin
            out_valid_d = 1'b0;
        end
    end

    // Stall counter saturates and is held across a flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stalled && !flush_IN && (stall_cnt_q != stall_cnt_max())) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StArb;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        pushReq_OUT  = out_valid_q;
        pushData_OUT = out_data_q;
        pushSrc_OUT  = out_src_q;
        locked_OUT   = (state_q == StLocked);
        stallCnt_OUT = stall_cnt_q;
    end

endmodule

// File: tb/tb_queue_push_arbiter.sv
module tb_queue_push_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 4;
    localparam int unsigned NV = 30;

    logic          clk;
    logic          reset;
    logic [NR-1:0] req;
    logic [NR-1:0] lock;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0] grant;
    logic          qfull;
    logic          flush;
    logic          push_req;
    logic [DW-1:0] push_data;
    logic [1:0]    push_src;
    logic          locked;
    logic [15:0]   stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    queue_push_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .SRC_WIDTH  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_IN       (req),
        .lock_IN      (lock),
        .reqData_IN   (req_data),
        .grant_OUT    (grant),
        .qFull_IN     (qfull),
        .flush_IN     (flush),
        .pushReq_OUT  (push_req),
        .pushData_OUT (push_data),
        .pushSrc_OUT  (push_src),
        .locked_OUT   (locked),
        .stallCnt_OUT (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle and the outputs expected in that same cycle
    // (registered outputs reflect earlier edges, grant reflects these inputs).
    // dchk: 0 = data not checked, 1 = pdata(src), 2 = zero.
    typedef struct {
        logic        rst;
        logic        flush;
        logic        full;
        logic [3:0]  req;
        logic [3:0]  lock;
        logic [3:0]  gnt;
        logic        pv;
        logic [1:0]  src;
        logic        lck;
        logic [15:0] stall;
        logic [1:0]  dchk;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(logic rst, logic fl, logic fu, logic [3:0] rq, logic [3:0] lk,
                                logic [3:0] g, logic pv, logic [1:0] src, logic lck,
                                logic [15:0] st, logic [1:0] dc);
        vec_t v;
        v.rst = rst; v.flush = fl; v.full = fu; v.req = rq; v.lock = lk;
        v.gnt = g; v.pv = pv; v.src = src; v.lck = lck; v.stall = st; v.dchk = dc;
        return v;
    endfunction

    function automatic logic [DW-1:0] pdata(int unsigned i);
        return 32'hDA7A_0000 | (32'(i) << 8) | 32'(i + 3);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = pdata(i);
        reset = 1'b1; flush = 1'b0; qfull = 1'b0; req = '0; lock = '0;
        repeat (2) @(posedge clk);

        //             rst fl fu req      lock     gnt      pv src lck stall dchk
        vecs[0]  = mk(1, 0, 0, 4'b1111, 4'b0000, 4'b0000, 0, 0, 0, 0, 2);
        // Round robin with all requesting.
        vecs[1]  = mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0001, 0, 0, 0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0010, 1, 0, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0100, 1, 1, 0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 4'b1111, 4'b0000, 4'b1000, 1, 2, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0001, 1, 3, 0, 0, 1);
        vecs[6]  = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 1);
        vecs[7]  = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
        // Burst lock by producer 2, then release hands over to producer 0.
        vecs[8]  = mk(0, 0, 0, 4'b0101, 4'b0100, 4'b0100, 0, 0, 0, 0, 0);
        vecs[9]  = mk(0, 0, 0, 4'b0101, 4'b0100, 4'b0100, 1, 2, 1, 0, 1);
        vecs[10] = mk(0, 0, 0, 4'b0101, 4'b0100, 4'b0100, 1, 2, 1, 0, 1);
        vecs[11] = mk(0, 0, 0, 4'b0101, 4'b0000, 4'b0001, 1, 2, 1, 0, 1);
        vecs[12] = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 1);
        // Stage holds producer 1 through five full cycles.
        vecs[13] = mk(0, 0, 0, 4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0, 1, 4'b1000, 4'b0000, 4'b0000, 1, 1, 0, 0, 1);
        vecs[15] = mk(0, 0, 1, 4'b1000, 4'b0000, 4'b0000, 1, 1, 0, 1, 1);
        vecs[16] = mk(0, 0, 1, 4'b1000, 4'b0000, 4'b0000, 1, 1, 0, 2, 1);
        vecs[17] = mk(0, 0, 1, 4'b1000, 4'b0000, 4'b0000, 1, 1, 0, 3, 1);
        vecs[18] = mk(0, 0, 1, 4'b1000, 4'b0000, 4'b0000, 1, 1, 0, 4, 1);
        vecs[19] = mk(0, 0, 0, 4'b1000, 4'b0000, 4'b1000, 1, 1, 0, 5, 1);
        vecs[20] = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 3, 0, 5, 1);
        // Flush while locked with a valid stage.
        vecs[21] = mk(0, 0, 0, 4'b0001, 4'b0001, 4'b0001, 0, 3, 0, 5, 0);
        vecs[22] = mk(0, 1, 0, 4'b0001, 4'b0001, 4'b0000, 1, 0, 1, 5, 1);
        vecs[23] = mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0010, 0, 0, 0, 5, 0);
        vecs[24] = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 5, 1);
        // Reset with flush mid-burst and mid-stall.
        vecs[25] = mk(0, 0, 0, 4'b0100, 4'b0100, 4'b0100, 0, 1, 0, 5, 0);
        vecs[26] = mk(0, 0, 1, 4'b0100, 4'b0100, 4'b0000, 1, 2, 1, 5, 1);
        vecs[27] = mk(1, 1, 1, 4'b0100, 4'b0100, 4'b0000, 1, 2, 1, 6, 1);
        vecs[28] = mk(0, 0, 0, 4'b1111, 4'b0000, 4'b0001, 0, 0, 0, 0, 2);
        vecs[29] = mk(0, 0, 0, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, 0, 1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; flush = vecs[i].flush; qfull = vecs[i].full;
            req = vecs[i].req; lock = vecs[i].lock;
            #1;
            check($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].gnt));
            check($sformatf("v%0d pushReq", i), 32'(push_req), 32'(vecs[i].pv));
            check($sformatf("v%0d pushSrc", i), 32'(push_src), 32'(vecs[i].src));
            check($sformatf("v%0d locked", i), 32'(locked), 32'(vecs[i].lck));
            check($sformatf("v%0d stallCnt", i), 32'(stall_cnt), 32'(vecs[i].stall));
            if (vecs[i].dchk == 2'd1)
                check($sformatf("v%0d pushData", i), push_data, pdata(int'(vecs[i].src)));
            else if (vecs[i].dchk == 2'd2)
                check($sformatf("v%0d pushData zero", i), push_data, 32'h0);
        end

        // Stall counter saturation over a long stall.
        @(negedge clk);
        req = 4'b0001; qfull = 1'b0;
        #1 check("sat load grant", 32'(grant), 32'h1);
        @(negedge clk);
        req = 4'b0010; qfull = 1'b1;
        #1 check("sat stalled grant", 32'(grant), 32'h0);
        repeat (65534) @(negedge clk);
        #1 check("sat cnt FFFE", 32'(stall_cnt), 32'hFFFE);
        @(negedge clk);
        #1 check("sat cnt FFFF", 32'(stall_cnt), 32'hFFFF);
        repeat (3) @(negedge clk);
        #1;
        check("sat cnt held", 32'(stall_cnt), 32'hFFFF);
        check("sat pushReq", 32'(push_req), 32'h1);
        check("sat pushData", push_data, pdata(0));
        check("sat grant", 32'(grant), 32'h0);
        qfull = 1'b0;
        #1 check("sat release grant", 32'(grant), 32'h2);
        @(negedge clk);
        req = 4'b0000;
        #1;
        check("sat next src", 32'(push_src), 32'h1);
        check("sat next data", push_data, pdata(1));
        check("sat cnt after", 32'(stall_cnt), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
